// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared encodings and field positions for the instruction fetch unit
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int IMM_W       = 16;
    localparam int INSTR_BYTES = 4;

    // Branch immediates count words, so shift left by two and sign-extend to a byte offset.
    function automatic logic [31:0] sext_word_offset(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// rtl/branch_target_adder.sv - combinational sequential/branch next-PC selection
module branch_target_adder
    import mips_fetch_pkg::*;
(
    input  logic [31:0]      i_pc,
    input  logic [IMM_W-1:0] i_imm,
    input  logic             i_branch_eq,
    input  logic             i_branch_ne,
    input  logic             i_zero,
    output logic [31:0]      o_pc_plus4,
    output logic [31:0]      o_target,
    output logic [31:0]      o_next_pc
);

    logic w_taken;

    assign o_pc_plus4 = i_pc + 32'(INSTR_BYTES);
    assign o_target   = o_pc_plus4 + sext_word_offset(i_imm);
    // Both branch flags together always take: one of the two terms is true for any zero value.
    assign w_taken    = (i_branch_eq & i_zero) | (i_branch_ne & ~i_zero);
    assign o_next_pc  = w_taken ? o_target : o_pc_plus4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, imem req/ack fetch FSM and instruction register
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    input  logic             branch_eq_i,
    input  logic             branch_ne_i,
    input  logic             zero_i,
    output logic             instr_valid_o,
    output logic [31:0]      instr_o,
    output logic [5:0]       opcode_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic [CNT_W-1:0] retired_o
);

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_valid;
    logic             r_req;
    logic [CNT_W-1:0] r_retired;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_target;
    logic [31:0]      w_next_pc;

    branch_target_adder u_bta (
        .i_pc        (r_pc),
        .i_imm       (r_instr[IMM_W-1:0]),
        .i_branch_eq (branch_eq_i),
        .i_branch_ne (branch_ne_i),
        .i_zero      (zero_i),
        .o_pc_plus4  (w_pc_plus4),
        .o_target    (w_target),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pc      <= PC_RESET;
            r_instr   <= '0;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack_i) begin
                        r_instr <= imem_rdata_i;
                        r_state <= ISSUE;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Branch inputs only matter on the retiring edge; stalled cycles ignore them.
                    if (!stall_i) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= FETCH;
                        r_req     <= 1'b1;
                        r_valid   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_pc;
    assign instr_valid_o = r_valid;
    assign instr_o       = r_instr;
    assign opcode_o      = r_instr[OPCODE_MSB:OPCODE_LSB];
    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;
    assign retired_o     = r_retired;

endmodule
